// File: rtl/regfile_param_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | regfile_param_if : write, read and scoreboard bus of the register file |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface regfile_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
);
  logic                     we0;
  logic [ADDR_W-1:0]        waddr0;
  logic [DATA_W-1:0]        wdata0;
  logic                     we1;
  logic [ADDR_W-1:0]        waddr1;
  logic [DATA_W-1:0]        wdata1;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     busy_set;
  logic [ADDR_W-1:0]        busy_addr;
  logic [NUM_RD-1:0]        rbusy;
  logic                     wr_conflict;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, busy_set, busy_addr,
    input  rdata, rbusy, wr_conflict
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, busy_set, busy_addr,
    output rdata, rbusy, wr_conflict
  );
endinterface
`default_nettype wire

// File: rtl/regfile_param.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | regfile_param : multi-read, dual-write register file with busy bits    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  regfile_param_if.slave    bus
);
  localparam int unsigned c_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]        mem_q [c_DEPTH];
  logic [c_DEPTH-1:0]       busy_q;
  logic [c_DEPTH-1:0]       busy_d;
  logic                     wr_conflict_q;
  logic                     wr_conflict_d;

  logic                     w_we0;
  logic                     w_we1;
  logic                     w_set;
  logic [NUM_RD*DATA_W-1:0] w_rdata;
  logic [NUM_RD-1:0]        w_rbusy;

  // Writes and busy marks aimed at a hardwired zero register are dropped here.
  assign w_we0 = bus.we0 & ~((ZERO_REG != 0) && (bus.waddr0 == '0));
  assign w_we1 = bus.we1 & ~((ZERO_REG != 0) && (bus.waddr1 == '0));
  assign w_set = bus.busy_set & ~((ZERO_REG != 0) && (bus.busy_addr == '0));

  assign wr_conflict_d = bus.we0 & bus.we1 & (bus.waddr0 == bus.waddr1) &
                         ~((ZERO_REG != 0) && (bus.waddr0 == '0));

  always_comb begin
    busy_d = busy_q;
    if (w_we0) busy_d[bus.waddr0] = 1'b0;
    if (w_we1) busy_d[bus.waddr1] = 1'b0;
    if (w_set) busy_d[bus.busy_addr] = 1'b1;
  end

  // Port 1 is written last so it owns the entry on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q        <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      if (w_we0) mem_q[bus.waddr0] <= bus.wdata0;
      if (w_we1) mem_q[bus.waddr1] <= bus.wdata1;
      busy_q        <= busy_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;
    logic              w_rb;

    assign w_ra = bus.raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_rd = mem_q[w_ra];
      w_rb = busy_q[w_ra];
      if (BYPASS != 0) begin
        if (w_we0 && (bus.waddr0 == w_ra)) begin
          w_rd = bus.wdata0;
          w_rb = 1'b0;
        end
        if (w_we1 && (bus.waddr1 == w_ra)) begin
          w_rd = bus.wdata1;
          w_rb = 1'b0;
        end
      end
      if ((ZERO_REG != 0) && (w_ra == '0)) begin
        w_rd = '0;
        w_rb = 1'b0;
      end
      // Outputs are forced quiet for the whole time reset is held.
      if (rst) begin
        w_rd = '0;
        w_rb = 1'b0;
      end
    end

    assign w_rdata[k*DATA_W +: DATA_W] = w_rd;
    assign w_rbusy[k]                  = w_rb;
  end

  assign bus.rdata       = w_rdata;
  assign bus.rbusy       = w_rbusy;
  assign bus.wr_conflict = wr_conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_regfile_param : three configurations against an array-based model   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_regfile_param;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR  = 2;
  localparam int CDW = 64;
  localparam int CAW = 3;
  localparam int CNR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut_a: bypass on, dut_b: bypass off (same stimulus), dut_c: wide, no zero reg
  regfile_param_if #(.DATA_W(DW),  .ADDR_W(AW),  .NUM_RD(NR))  if_a ();
  regfile_param_if #(.DATA_W(DW),  .ADDR_W(AW),  .NUM_RD(NR))  if_b ();
  regfile_param_if #(.DATA_W(CDW), .ADDR_W(CAW), .NUM_RD(CNR)) if_c ();

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  regfile_param #(.DATA_W(CDW), .ADDR_W(CAW), .NUM_RD(CNR), .ZERO_REG(0), .BYPASS(1))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  logic                 we0, we1, busy_set;
  logic [AW-1:0]        waddr0, waddr1, busy_addr;
  logic [DW-1:0]        wdata0, wdata1;
  logic [NR*AW-1:0]     raddr;

  logic                 c_we0, c_we1, c_busy_set;
  logic [CAW-1:0]       c_waddr0, c_waddr1, c_busy_addr;
  logic [CDW-1:0]       c_wdata0, c_wdata1;
  logic [CNR*CAW-1:0]   c_raddr;

  assign if_a.we0 = we0;         assign if_b.we0 = we0;
  assign if_a.waddr0 = waddr0;   assign if_b.waddr0 = waddr0;
  assign if_a.wdata0 = wdata0;   assign if_b.wdata0 = wdata0;
  assign if_a.we1 = we1;         assign if_b.we1 = we1;
  assign if_a.waddr1 = waddr1;   assign if_b.waddr1 = waddr1;
  assign if_a.wdata1 = wdata1;   assign if_b.wdata1 = wdata1;
  assign if_a.raddr = raddr;     assign if_b.raddr = raddr;
  assign if_a.busy_set = busy_set;   assign if_b.busy_set = busy_set;
  assign if_a.busy_addr = busy_addr; assign if_b.busy_addr = busy_addr;

  assign if_c.we0 = c_we0;
  assign if_c.waddr0 = c_waddr0;
  assign if_c.wdata0 = c_wdata0;
  assign if_c.we1 = c_we1;
  assign if_c.waddr1 = c_waddr1;
  assign if_c.wdata1 = c_wdata1;
  assign if_c.raddr = c_raddr;
  assign if_c.busy_set = c_busy_set;
  assign if_c.busy_addr = c_busy_addr;

  // Reference model: register contents and pending flags as plain arrays
  logic [DW-1:0]  m_data [32];
  bit             m_busy [32];
  bit             m_conf;
  logic [CDW-1:0] cm_data [8];
  bit             cm_busy [8];
  bit             cm_conf;

  typedef struct {
    int          dut;   // 0 = a, 1 = b, 2 = c
    int          kind;  // 0 = rdata, 1 = rbusy, 2 = wr_conflict
    int          port;
    logic [63:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] actual(exp_t e);
    logic [63:0] v;
    v = '0;
    case (e.dut)
      0: case (e.kind)
           0: v = {32'h0, if_a.rdata[e.port*DW +: DW]};
           1: v = {63'h0, if_a.rbusy[e.port]};
           default: v = {63'h0, if_a.wr_conflict};
         endcase
      1: case (e.kind)
           0: v = {32'h0, if_b.rdata[e.port*DW +: DW]};
           1: v = {63'h0, if_b.rbusy[e.port]};
           default: v = {63'h0, if_b.wr_conflict};
         endcase
      default: case (e.kind)
           0: v = if_c.rdata[e.port*CDW +: CDW];
           1: v = {63'h0, if_c.rbusy[e.port]};
           default: v = {63'h0, if_c.wr_conflict};
         endcase
    endcase
    return v;
  endfunction

  exp_t        mon_e;
  logic [63:0] mon_act;
  string       mon_name;

  always @(negedge clk) begin
    while (exp_q.size() != 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = actual(mon_e);
      checks++;
      if (mon_act !== mon_e.exp) begin
        errors++;
        mon_name = (mon_e.kind == 0) ? "rdata" : (mon_e.kind == 1) ? "rbusy" : "wr_conflict";
        $display("FAIL dut_%s %s port %0d at %0t: got %h expected %h",
                 (mon_e.dut == 0) ? "a" : (mon_e.dut == 1) ? "b" : "c",
                 mon_name, mon_e.port, $time, mon_act, mon_e.exp);
      end
    end
  end

  task automatic push(int dut, int kind, int port, logic [63:0] v);
    exp_t e;
    e.dut = dut; e.kind = kind; e.port = port; e.exp = v;
    exp_q.push_back(e);
  endtask

  function automatic logic [DW-1:0] ab_data(int a, bit byp);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = m_data[a];
    if (byp && we0 && int'(waddr0) == a) v = wdata0;
    if (byp && we1 && int'(waddr1) == a) v = wdata1;
    return v;
  endfunction

  function automatic bit ab_busy(int a, bit byp);
    if (a == 0) return 1'b0;
    if (byp && ((we0 && int'(waddr0) == a) || (we1 && int'(waddr1) == a))) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [CDW-1:0] c_data(int a);
    logic [CDW-1:0] v;
    v = cm_data[a];
    if (c_we0 && int'(c_waddr0) == a) v = c_wdata0;
    if (c_we1 && int'(c_waddr1) == a) v = c_wdata1;
    return v;
  endfunction

  function automatic bit c_busy(int a);
    if ((c_we0 && int'(c_waddr0) == a) || (c_we1 && int'(c_waddr1) == a)) return 1'b0;
    return cm_busy[a];
  endfunction

  task automatic model_edge();
    if (we0 && waddr0 != '0) begin m_data[waddr0] = wdata0; m_busy[waddr0] = 1'b0; end
    if (we1 && waddr1 != '0) begin m_data[waddr1] = wdata1; m_busy[waddr1] = 1'b0; end
    if (busy_set && busy_addr != '0) m_busy[busy_addr] = 1'b1;
    m_conf = we0 && we1 && (waddr0 == waddr1) && (waddr0 != '0);
    if (c_we0) begin cm_data[c_waddr0] = c_wdata0; cm_busy[c_waddr0] = 1'b0; end
    if (c_we1) begin cm_data[c_waddr1] = c_wdata1; cm_busy[c_waddr1] = 1'b0; end
    if (c_busy_set) cm_busy[c_busy_addr] = 1'b1;
    cm_conf = c_we0 && c_we1 && (c_waddr0 == c_waddr1);
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; busy_set = 0;
    c_we0 = 0; c_we1 = 0; c_busy_set = 0;
  endtask

  // One clock: queue expectations for the current drive, then advance the model.
  task automatic step();
    int a;
    for (int k = 0; k < NR; k++) begin
      a = int'(raddr[k*AW +: AW]);
      push(0, 0, k, {32'h0, ab_data(a, 1'b1)});
      push(0, 1, k, {63'h0, ab_busy(a, 1'b1)});
      push(1, 0, k, {32'h0, ab_data(a, 1'b0)});
      push(1, 1, k, {63'h0, ab_busy(a, 1'b0)});
    end
    push(0, 2, 0, {63'h0, m_conf});
    push(1, 2, 0, {63'h0, m_conf});
    for (int k = 0; k < CNR; k++) begin
      a = int'(c_raddr[k*CAW +: CAW]);
      push(2, 0, k, c_data(a));
      push(2, 1, k, {63'h0, c_busy(a)});
    end
    push(2, 2, 0, {63'h0, cm_conf});
    @(negedge clk);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Reset asserted between edges: everything must read zero at once.
  task automatic reset_pulse();
    idle();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin m_data[i] = '0; m_busy[i] = 1'b0; end
    for (int i = 0; i < 8; i++) begin cm_data[i] = '0; cm_busy[i] = 1'b0; end
    m_conf = 1'b0;
    cm_conf = 1'b0;
    #1;
    for (int k = 0; k < NR; k++) begin
      push(0, 0, k, 64'h0); push(0, 1, k, 64'h0);
      push(1, 0, k, 64'h0); push(1, 1, k, 64'h0);
    end
    push(0, 2, 0, 64'h0);
    push(1, 2, 0, 64'h0);
    for (int k = 0; k < CNR; k++) begin
      push(2, 0, k, 64'h0); push(2, 1, k, 64'h0);
    end
    push(2, 2, 0, 64'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [AW-1:0] rand_ab_addr();
    return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
  endfunction

  initial begin
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; busy_addr = '0; raddr = '0;
    c_waddr0 = '0; c_waddr1 = '0; c_wdata0 = '0; c_wdata1 = '0; c_busy_addr = '0; c_raddr = '0;
    idle();
    reset_pulse();

    // Entry 5 loaded and marked pending, wide config writes address 0
    we0 = 1; waddr0 = 5'd5; wdata0 = 32'h1234_5678; busy_set = 1; busy_addr = 5'd5;
    raddr = {5'd0, 5'd5};
    c_we0 = 1; c_waddr0 = '0; c_wdata0 = 64'h0123_4567_89AB_CDEF;
    c_busy_set = 1; c_busy_addr = '0; c_raddr = '0;
    step();
    idle();
    step();
    reset_pulse();

    // Register 0 ignores writes; port 0 reads addr 7, port 1 reads addr 0
    we0 = 1; waddr0 = 5'd7; wdata0 = 32'hDEAD_BEEF;
    we1 = 1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF;
    raddr = {5'd0, 5'd7};
    c_we0 = 1; c_waddr0 = '0; c_wdata0 = 64'h0123_4567_89AB_CDEF;
    c_busy_set = 1; c_busy_addr = '0;
    step();
    idle();
    step();

    // Same-address collision: port 1 wins, conflict flag for one cycle
    we0 = 1; waddr0 = 5'd3; wdata0 = 32'hAAAA_AAAA;
    we1 = 1; waddr1 = 5'd3; wdata1 = 32'h5555_5555;
    raddr = {5'd7, 5'd3};
    step();
    idle();
    step();
    step();

    // Bypass of a same-cycle write
    we0 = 1; waddr0 = 5'd9; wdata0 = 32'h1;
    raddr = {5'd3, 5'd9};
    step();
    wdata0 = 32'h22;
    step();
    idle();
    step();

    // Scoreboard set, clear by write, and set-beats-clear
    busy_set = 1; busy_addr = 5'd12; raddr = {5'd9, 5'd12};
    step();
    idle();
    step();
    we1 = 1; waddr1 = 5'd12; wdata1 = 32'hCAFE_0012;
    step();
    idle();
    step();
    busy_set = 1; busy_addr = 5'd12; we0 = 1; waddr0 = 5'd12; wdata0 = 32'h0BAD_F00D;
    step();
    idle();
    step();

    // Randomised traffic on all three configurations
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset_pulse();
      end else begin
        we0 = 1'($urandom); we1 = 1'($urandom); busy_set = 1'($urandom);
        waddr0 = rand_ab_addr();
        waddr1 = ($urandom_range(0, 3) == 0) ? waddr0 : rand_ab_addr();
        busy_addr = ($urandom_range(0, 3) == 0) ? waddr1 : rand_ab_addr();
        wdata0 = $urandom; wdata1 = $urandom;
        raddr = {rand_ab_addr(), rand_ab_addr()};
        c_we0 = 1'($urandom); c_we1 = 1'($urandom); c_busy_set = 1'($urandom);
        c_waddr0 = CAW'($urandom); c_waddr1 = CAW'($urandom); c_busy_addr = CAW'($urandom);
        c_wdata0 = {$urandom, $urandom}; c_wdata1 = {$urandom, $urandom};
        c_raddr = CNR*CAW'($urandom);
        step();
      end
    end

    idle();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port register file for the pipelined MIPS datapath. It provides NUM_RD asynchronous read ports, two synchronous write ports (ALU/WB and load/late-WB), and an optional hardwired zero register. Optional write-to-read bypass lets decode see values written in the same cycle. A per-register busy scoreboard supports issue-side hazard detection. It sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to reads and busy cleared for reads

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (priority port)
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- raddr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
- busy_set  in  1  mark busy_addr pending (instruction issued with this destination)
- busy_addr  in  ADDR_W  destination register to mark pending
- rbusy  out  NUM_RD  per read port: addressed register pending
- wr_conflict  out  1  registered flag: both ports wrote the same address last cycle

## Operation
- Storage: 2**ADDR_W entries of DATA_W bits, plus 2**ADDR_W busy bits.
- Reset (async, rst=1): all entries and busy bits cleared to 0, wr_conflict=0. rdata reads 0 and rbusy=0 for all ports while rst is held.
- Writes: on a rising edge, weN=1 writes wdataN to entry waddrN. If we0 and we1 are both set and waddr0==waddr1, port 1's data is stored.
- Zero register (ZERO_REG=1): writes to address 0 are dropped on both ports. A read of address 0 returns 0 regardless of BYPASS. busy_set to address 0 is ignored.
- Reads (combinational): rdata[k] = entry[raddr[k]].
  - With BYPASS=1, the read value is overridden by the matching write data this cycle; port 1 wins over port 0.
  - With BYPASS=0, the read returns the pre-edge value.
- Scoreboard, per edge:
  - A write on either port to address a clears busy[a].
  - busy_set sets busy[busy_addr].
  - If a set and a clear target the same address in the same edge, the set wins and the bit ends at 1.
- rbusy[k] = busy[raddr[k]], with these overrides:
  - With BYPASS=1, it is forced to 0 when a write hits raddr[k] this cycle.
  - It is always 0 for address 0 when ZERO_REG=1.
- wr_conflict: registered each edge as we0 & we1 & (waddr0==waddr1) & !(ZERO_REG & waddr0==0). It stays high only while the condition repeats. It is a status output only.

## Timing
- Write latency: 1 edge. Data is visible on rdata immediately after the edge, or in the same cycle through BYPASS.
- busy_set takes effect at the next edge. rbusy reflects it in the following cycle.
- Read path is purely combinational: raddr/we/waddr/wdata → rdata/rbusy. There is no read latency.
- wr_conflict updates 1 cycle after the colliding writes.
- rst asserted mid-operation discards in-flight writes and busy_set in that cycle. The first write after rst deasserts lands at the first rising edge with rst=0.
- The same address on several read ports is legal; all ports return identical data.

## Test plan
- Reset: load entry 5 = 0x1234_5678 and mark busy[5]; pulse rst between edges → rdata of port 0 at addr 5 = 0 and rbusy[0]=0 immediately, before the next edge.
- Write/read and zero register: we0, addr 7 = 0xDEAD_BEEF; we1, addr 0 = 0xFFFF_FFFF → after the edge, port 0 (addr 7) = 0xDEADBEEF and port 1 (addr 0) = 0.
- Dual-write collision: we0 and we1 both at addr 3 with 0xAAAA_AAAA and 0x5555_5555 → entry 3 = 0x55555555, and wr_conflict=1 for exactly one cycle.
- Bypass (BYPASS=1): entry 9 = 0x1; in the same cycle drive we0 addr 9 = 0x22 and raddr port 0 = 9 → rdata = 0x22 before the edge. With BYPASS=0 the same stimulus → 0x1 before the edge and 0x22 after it.
- Scoreboard: busy_set addr 12 → rbusy=1 next cycle. Write port 1 to addr 12 → rbusy=1 before the edge (BYPASS=0) and 0 after it. Simultaneous busy_set and write on addr 12 → busy remains 1.
- Parameter sweep: DATA_W=64, ADDR_W=3, NUM_RD=4, ZERO_REG=0 → write 0x0123_4567_89AB_CDEF to addr 0 and read it on all 4 ports; all return the value and busy_set to addr 0 is honoured.
